// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC array sequencer.
package mac_seq_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned HALF_W      = 16;
   localparam int unsigned SEL_W       = 6;
   localparam int unsigned CFG_W       = 9;
   localparam int unsigned CFG_SAT_BIT = 0;
   localparam int unsigned CFG_RND_BIT = 1;
   localparam int unsigned CFG_TC_BIT  = 2;
   localparam int unsigned CFG_SEL_LSB = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [SEL_W-1:0] out_sel;
      logic             tc;
      logic             rnd;
      logic             sat;
   } cfg_t;

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter with a registered zero flag; load wins over decrement,
// and decrement saturates at zero.
module mac_seq_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         zero_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/mac_array_seq.sv
// Sequencer feeding operand/coefficient beats into an external MAC array and
// returning the accumulated result over a valid/ready response channel.
module mac_array_seq
   import mac_seq_pkg::*;
#(
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned MAC_LAT = 1
) (
   input  logic              MAC_ACC_CLK,
   input  logic              acc_ff_rstn,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [LEN_W-1:0]  CMD_LEN,
   input  logic [CFG_W-1:0]  CMD_CFG,
   input  logic              CMD_ABORT,
   input  logic              S_VALID,
   output logic              S_READY,
   input  logic [DATA_W-1:0] S_OPER,
   input  logic [DATA_W-1:0] S_COEF,
   output logic [DATA_W-1:0] MAC_OPER_DATA,
   output logic [DATA_W-1:0] MAC_COEF_DATA,
   output logic              EFPGA_MATHB_CLK_EN,
   output logic              MAC_ACC_CLEAR,
   output logic [SEL_W-1:0]  MAC_OUT_SEL,
   output logic              MAC_TC,
   output logic              MAC_ACC_RND,
   output logic              MAC_ACC_SAT,
   input  logic [DATA_W-1:0] MAC0_OUT,
   input  logic [HALF_W-1:0] MAC1_OUT,
   input  logic [HALF_W-1:0] MAC2_OUT,
   output logic              R_VALID,
   input  logic              R_READY,
   output logic [DATA_W-1:0] R_DATA0,
   output logic [DATA_W-1:0] R_DATA1,
   output logic              BUSY
);

   localparam int unsigned LAT_W = $clog2(MAC_LAT + 2);
   localparam int unsigned CNT_W = (LEN_W > LAT_W) ? LEN_W : LAT_W;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] oper_q, oper_d, coef_q, coef_d;
   logic [DATA_W-1:0] r_data0_q, r_data0_d, r_data1_q, r_data1_d;
   cfg_t              cfg_q, cfg_d;
   logic              clk_en_q, clk_en_d;
   logic              clear_q, clear_d;
   logic              first_q, first_d;
   logic              r_valid_q, r_valid_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              s_ready_q, s_ready_d;
   logic              busy_q, busy_d;

   logic              cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]  cnt_val;

   // One counter is time-shared: remaining beats in RUN, remaining drain cycles in DRAIN.
   mac_seq_cnt #(.W(CNT_W)) u_cnt (
      .clk    (MAC_ACC_CLK),
      .rst_n  (acc_ff_rstn),
      .load_i (cnt_load),
      .val_i  (cnt_val),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   always_comb begin
      state_d   = state_q;
      oper_d    = oper_q;
      coef_d    = coef_q;
      r_data0_d = r_data0_q;
      r_data1_d = r_data1_q;
      cfg_d     = cfg_q;
      clk_en_d  = 1'b0;
      clear_d   = 1'b0;
      first_d   = first_q;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      cnt_dec   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               cfg_d.out_sel = CMD_CFG[CFG_SEL_LSB +: SEL_W];
               cfg_d.tc      = CMD_CFG[CFG_TC_BIT];
               cfg_d.rnd     = CMD_CFG[CFG_RND_BIT];
               cfg_d.sat     = CMD_CFG[CFG_SAT_BIT];
               first_d       = 1'b1;
               if (CMD_LEN != '0) begin
                  // Count holds beats still owed after the current one.
                  state_d  = ST_RUN;
                  cnt_load = 1'b1;
                  cnt_val  = CNT_W'(CMD_LEN - LEN_W'(1));
               end else begin
                  state_d   = ST_RESP;
                  r_data0_d = '0;
                  r_data1_d = '0;
               end
            end
         end
         ST_RUN: begin
            if (CMD_ABORT) begin
               state_d = ST_IDLE;
            end else if (S_VALID) begin
               oper_d   = S_OPER;
               coef_d   = S_COEF;
               clk_en_d = 1'b1;
               clear_d  = first_q;
               first_d  = 1'b0;
               if (cnt_zero) begin
                  state_d  = ST_DRAIN;
                  cnt_load = 1'b1;
                  cnt_val  = CNT_W'(MAC_LAT);
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (CMD_ABORT) begin
               state_d = ST_IDLE;
            end else if (cnt_zero) begin
               state_d   = ST_RESP;
               r_data0_d = MAC0_OUT;
               r_data1_d = {MAC1_OUT, MAC2_OUT};
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RESP: begin
            if (CMD_ABORT || R_READY) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      s_ready_d   = (state_d == ST_RUN);
      r_valid_d   = (state_d == ST_RESP);
   end

   always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
      if (!acc_ff_rstn) begin
         state_q     <= ST_IDLE;
         oper_q      <= '0;
         coef_q      <= '0;
         r_data0_q   <= '0;
         r_data1_q   <= '0;
         cfg_q       <= '0;
         clk_en_q    <= 1'b0;
         clear_q     <= 1'b0;
         first_q     <= 1'b0;
         r_valid_q   <= 1'b0;
         cmd_ready_q <= 1'b1;
         s_ready_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         oper_q      <= oper_d;
         coef_q      <= coef_d;
         r_data0_q   <= r_data0_d;
         r_data1_q   <= r_data1_d;
         cfg_q       <= cfg_d;
         clk_en_q    <= clk_en_d;
         clear_q     <= clear_d;
         first_q     <= first_d;
         r_valid_q   <= r_valid_d;
         cmd_ready_q <= cmd_ready_d;
         s_ready_q   <= s_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign CMD_READY          = cmd_ready_q;
   assign S_READY            = s_ready_q;
   assign BUSY               = busy_q;
   assign MAC_OPER_DATA      = oper_q;
   assign MAC_COEF_DATA      = coef_q;
   assign EFPGA_MATHB_CLK_EN = clk_en_q;
   assign MAC_ACC_CLEAR      = clear_q;
   assign MAC_OUT_SEL        = cfg_q.out_sel;
   assign MAC_TC             = cfg_q.tc;
   assign MAC_ACC_RND        = cfg_q.rnd;
   assign MAC_ACC_SAT        = cfg_q.sat;
   assign R_VALID            = r_valid_q;
   assign R_DATA0            = r_data0_q;
   assign R_DATA1            = r_data1_q;

endmodule

// File: doc/mac_array_seq.md
MAC_ARRAY_SEQ -- requirements
Module: mac_array_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the term-count field.
REQ-002 SHALL have parameter MAC_LAT, default 1: cycles from the last enabled MAC edge to a valid MAC0_OUT.
REQ-003 SHALL have port MAC_ACC_CLK  in  1: the single clock; all flops on its rising edge.
REQ-004 SHALL have port acc_ff_rstn  in  1: asynchronous, active-low reset.
REQ-005 SHALL have ports CMD_VALID in 1 / CMD_READY out 1: command handshake.
REQ-006 SHALL have port CMD_LEN  in  LEN_W: number of operand/coefficient terms, 0 allowed.
REQ-007 SHALL have port CMD_CFG  in  9: {OUT_SEL[5:0], TC, RND, SAT}.
REQ-008 SHALL have port CMD_ABORT  in  1: abandon the current job.
REQ-009 SHALL have ports S_VALID in 1 / S_READY out 1: beat handshake.
REQ-010 SHALL have ports S_OPER in 32 / S_COEF in 32: beat payload.
REQ-011 SHALL have ports MAC_OPER_DATA out 32 / MAC_COEF_DATA out 32: MAC array operands.
REQ-012 SHALL have port EFPGA_MATHB_CLK_EN  out  1: MAC array accumulate enable.
REQ-013 SHALL have port MAC_ACC_CLEAR  out  1: first-term strobe (accumulator loads the product).
REQ-014 SHALL have ports MAC_OUT_SEL out 6, and MAC_TC, MAC_ACC_RND, MAC_ACC_SAT out 1 each: latched CMD_CFG.
REQ-015 SHALL have ports MAC0_OUT in 32, MAC1_OUT in 16, MAC2_OUT in 16: MAC array results.
REQ-016 SHALL have ports R_VALID out 1 / R_READY in 1, R_DATA0 out 32, R_DATA1 out 32: result handshake and data.
REQ-017 SHALL have port BUSY  out  1: high in any state other than IDLE.

Function
REQ-018 SHALL implement the states IDLE, RUN, DRAIN and RESP.
REQ-019 IDLE: CMD_READY=1; on CMD_VALID, latch CMD_LEN and CMD_CFG; next state is RUN if LEN>0, otherwise RESP with R_DATA0=R_DATA1=0.
REQ-020 RUN: S_READY=1 and CMD_READY=0; a beat accepted at edge k SHALL be registered onto MAC_OPER_DATA/MAC_COEF_DATA with EFPGA_MATHB_CLK_EN=1 for exactly cycle k+1.
REQ-021 MAC_ACC_CLEAR SHALL be 1 only in the cycle that carries beat 1 of a job.
REQ-022 Cycles without an accepted beat SHALL give EFPGA_MATHB_CLK_EN=0 and SHALL hold MAC_OPER_DATA/MAC_COEF_DATA.
REQ-023 After beat LEN is accepted, SHALL set S_READY=0 in the next cycle and enter DRAIN.
REQ-024 DRAIN SHALL last MAC_LAT+1 cycles; on exit it SHALL capture R_DATA0=MAC0_OUT and R_DATA1={MAC1_OUT,MAC2_OUT}, then enter RESP.
REQ-025 RESP: R_VALID=1, with R_DATA stable until R_READY; R_VALID&R_READY SHALL return to IDLE, so CMD_READY=1 the next cycle.
REQ-026 CMD_VALID outside IDLE SHALL be ignored.
REQ-027 CMD_ABORT in RUN, DRAIN or RESP SHALL force IDLE next cycle: R_VALID=0, EFPGA_MATHB_CLK_EN=0, no result produced; CMD_ABORT SHALL take priority over a simultaneous beat or R_READY.
REQ-028 The beat counter SHALL count LEN terms exactly, with no wrap: LEN=2^LEN_W-1 SHALL give 2^LEN_W-1 enabled edges.
REQ-029 MAC_OUT_SEL, MAC_TC, MAC_ACC_RND and MAC_ACC_SAT SHALL hold the latched configuration from command accept until the next accept.

Reset
REQ-030 While acc_ff_rstn=0: state IDLE; every registered output 0 (MAC_* data, EFPGA_MATHB_CLK_EN, MAC_ACC_CLEAR, R_VALID, R_DATA*, BUSY, S_READY); CMD_READY=1.
REQ-031 Reset asserted mid-job SHALL discard the job; no result is emitted after release.

Structure
REQ-032 A shared package mac_seq_pkg SHALL hold the state enum, the data width (32), the OUT_SEL width (6) and the CMD_CFG field positions.
REQ-033 One sub-module, mac_seq_cnt (a loadable down-counter with zero flag), SHALL be reused for both the beat count and the drain count.

Verification
REQ-034 CMD_LEN=4, CMD_CFG=0; beats oper=1,2,3,4, coef=2 back-to-back, with a behavioural MAC -> MAC_ACC_CLEAR on cycle 1 only, EFPGA_MATHB_CLK_EN for 4 cycles, R_DATA0=20, R_VALID MAC_LAT+2 cycles after the last beat.
REQ-035 CMD_LEN=3; S_VALID pattern 1,0,1,0,1 -> EFPGA_MATHB_CLK_EN pattern 1,0,1,0,1 delayed one cycle, MAC operands held in the gap cycles, result equal to the gapless case.
REQ-036 CMD_LEN=0 -> R_VALID=1 one cycle after accept, R_DATA0=R_DATA1=0, EFPGA_MATHB_CLK_EN never 1.
REQ-037 R_READY held 0 for 10 cycles while CMD_VALID=1 -> R_VALID/R_DATA stable, CMD_READY=0, no new job accepted.
REQ-038 CMD_ABORT after beat 2 of 5 -> IDLE next cycle, S_READY=0, R_VALID never asserted; the next command clears correctly.
REQ-039 acc_ff_rstn pulsed low in DRAIN -> all outputs 0 immediately (asynchronous), CMD_READY=1, no R_VALID afterwards.
